// File: rtl/seven_seg_scanner_pkg.sv
// Purpose : shared constants and types for the seven-segment scanner.
// Latency : n/a (package only).
// Backpr. : n/a.
// Contents: segment table (active-low {g,f,e,d,c,b,a}), blank/off constants,
//           scanner FSM state type, default blanking length.
package seven_seg_scanner_pkg;

   localparam int         BLANK_CYCLES_DEF = 4;
   localparam logic [6:0] SEG_OFF          = 7'h7F;
   localparam logic [3:0] AN_OFF           = 4'hF;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } scan_state_t;

   // Index is the hex value; glyphs 0-9, A, b, C, d, E, F.
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Purpose : hex nibble to active-low seven-segment pattern.
// Latency : combinational.
// Backpr. : none.
// Ports   : hex_i - 4-bit value; seg_o - {g,f,e,d,c,b,a}, active-low.
module seg7_hex_decoder
   import seven_seg_scanner_pkg::*;
(
   input  logic [3:0] hex_i,
   output logic [6:0] seg_o
);

   assign seg_o = SEG_TABLE[hex_i];

endmodule

// File: rtl/seven_seg_scanner.sv
// Purpose : 4-digit multiplexed seven-segment driver with anode blanking,
//           leading-zero suppression and frame-aligned digit updates.
// Latency : refresh_count change at edge N -> anodes off after N+1 -> new
//           digit after N+1+BLANK_CYCLES; load commits at next 3->0 boundary.
// Backpr. : none; load is never refused, a newer load overwrites a pending one.
// Ports   : clk/rst_n (async active-low); refresh_count digit select;
//           digits_in/dp_in/load capture request; load_ack commit pulse;
//           an/seg/dp registered active-low display drives.
module seven_seg_scanner
   import seven_seg_scanner_pkg::*;
#(
   parameter int BLANK_CYCLES = BLANK_CYCLES_DEF,
   parameter bit LZ_SUPPRESS  = 1'b1
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  refresh_count,
   input  logic [15:0] digits_in,
   input  logic [3:0]  dp_in,
   input  logic        load,
   output logic        load_ack,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam int CW = (BLANK_CYCLES < 1) ? 1 : $clog2(BLANK_CYCLES + 1);

   scan_state_t     state_q;
   logic [CW-1:0]   cnt_q;
   logic [1:0]      prev_q;
   logic [15:0]     act_dig_q, act_dig_d, pend_dig_q, pend_dig_d;
   logic [3:0]      act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
   logic            pend_q, pend_d;
   logic            ack_q, ack_d;
   logic [3:0]      an_q;
   logic [6:0]      seg_q;
   logic            dp_q;

   logic            change;
   logic            frame_bnd;
   logic            blanking;
   logic [3:0]      sup;
   logic [3:0]      cur_hex;
   logic [6:0]      dec_seg;

   assign change    = (refresh_count != prev_q);
   assign frame_bnd = (prev_q == 2'd3) && (refresh_count == 2'd0);
   // Outputs stay dark only while the counter is still short of the target,
   // so the digit appears on the same edge the FSM moves to DRIVE.
   assign blanking  = (state_q == ST_BLANK) && (cnt_q < CW'(BLANK_CYCLES));
   assign cur_hex   = act_dig_q[{prev_q, 2'b00} +: 4];

   seg7_hex_decoder u_dec (
      .hex_i (cur_hex),
      .seg_o (dec_seg)
   );

   // Suppression ripples down from the most significant digit; a lit
   // decimal point stops the ripple.
   always_comb begin
      sup[3] = LZ_SUPPRESS && (act_dig_q[15:12] == 4'd0) && !act_dp_q[3];
      sup[2] = sup[3] && (act_dig_q[11:8] == 4'd0) && !act_dp_q[2];
      sup[1] = sup[2] && (act_dig_q[7:4] == 4'd0) && !act_dp_q[1];
      sup[0] = 1'b0;
   end

   // Pending/active digit registers: active only moves at a frame boundary.
   always_comb begin
      act_dig_d  = act_dig_q;
      act_dp_d   = act_dp_q;
      pend_dig_d = pend_dig_q;
      pend_dp_d  = pend_dp_q;
      pend_d     = pend_q;
      ack_d      = 1'b0;
      if (frame_bnd && load) begin
         act_dig_d = digits_in;
         act_dp_d  = dp_in;
         pend_d    = 1'b0;
         ack_d     = 1'b1;
      end else if (frame_bnd && pend_q) begin
         act_dig_d = pend_dig_q;
         act_dp_d  = pend_dp_q;
         pend_d    = 1'b0;
         ack_d     = 1'b1;
      end else if (load) begin
         pend_dig_d = digits_in;
         pend_dp_d  = dp_in;
         pend_d     = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q     <= 2'd0;
         act_dig_q  <= '0;
         act_dp_q   <= '0;
         pend_dig_q <= '0;
         pend_dp_q  <= '0;
         pend_q     <= 1'b0;
         ack_q      <= 1'b0;
      end else begin
         prev_q     <= refresh_count;
         act_dig_q  <= act_dig_d;
         act_dp_q   <= act_dp_d;
         pend_dig_q <= pend_dig_d;
         pend_dp_q  <= pend_dp_d;
         pend_q     <= pend_d;
         ack_q      <= ack_d;
      end
   end

   // Scan FSM with registered display outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_BLANK;
         cnt_q   <= '0;
         an_q    <= AN_OFF;
         seg_q   <= SEG_OFF;
         dp_q    <= 1'b1;
      end else begin
         if (blanking) begin
            an_q  <= AN_OFF;
            seg_q <= SEG_OFF;
            dp_q  <= 1'b1;
         end else begin
            an_q  <= ~(4'b0001 << prev_q);
            seg_q <= sup[prev_q] ? SEG_OFF : dec_seg;
            dp_q  <= ~act_dp_q[prev_q];
         end
         case (state_q)
            ST_BLANK: begin
               if (change) begin
                  cnt_q <= '0;
               end else if (cnt_q == CW'(BLANK_CYCLES)) begin
                  state_q <= ST_DRIVE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            ST_DRIVE: begin
               if (change) begin
                  state_q <= ST_BLANK;
                  cnt_q   <= '0;
               end
            end
            default: begin
               state_q <= ST_BLANK;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign an       = an_q;
   assign seg      = seg_q;
   assign dp       = dp_q;
   assign load_ack = ack_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
module tb_seven_seg_scanner;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  refresh_count;
   logic [15:0] digits_in;
   logic [3:0]  dp_in;
   logic        load;
   logic        load_ack;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   int n_checks = 0;
   int n_err    = 0;
   int ack_cnt  = 0;

   // Bench model of the display contents.
   logic [1:0]  cur;
   logic [15:0] m_dig, m_pdig;
   logic [3:0]  m_dp, m_pdp;
   bit          m_pend;
   logic [11:0] sb[$];
   logic [11:0] shown;
   bit          have_shown;
   int          a0;

   seven_seg_scanner dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .refresh_count (refresh_count),
      .digits_in     (digits_in),
      .dp_in         (dp_in),
      .load          (load),
      .load_ack      (load_ack),
      .an            (an),
      .seg           (seg),
      .dp            (dp)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (load_ack === 1'b1) ack_cnt++;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish within time budget");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] hex7(input logic [3:0] h);
      case (h)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   // Expected {an, seg, dp} for digit idx of the model's active value.
   function automatic logic [11:0] exp_disp(input logic [1:0] idx);
      logic [3:0] nib;
      logic [3:0] a;
      bit         lead;
      lead = 1'b1;
      for (int i = 3; i >= int'(idx); i--) begin
         nib = m_dig[i*4 +: 4];
         if (i == 0 || nib != 4'd0 || m_dp[i]) lead = 1'b0;
      end
      nib = m_dig[int'(idx)*4 +: 4];
      a = 4'b1111;
      a[idx] = 1'b0;
      return {a, (lead ? 7'h7F : hex7(nib)), ~m_dp[idx]};
   endfunction

   task automatic idle(input int n, input string tag);
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         chk({tag, "_idle"}, {an, seg, dp}, shown);
         @(negedge clk);
      end
   endtask

   task automatic load_pulse(input logic [15:0] d, input logic [3:0] p, input string tag);
      digits_in = d; dp_in = p; load = 1'b1;
      m_pdig = d; m_pdp = p; m_pend = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_ldack"}, load_ack, 1'b0);
      chk({tag, "_ldhold"}, {an, seg, dp}, shown);
      @(negedge clk);
      load = 1'b0;
   endtask

   // Move refresh_count to c (optionally with a coincident load) and check
   // hold, blanking and the newly driven digit.
   task automatic step(input logic [1:0] c, input bit ld, input logic [15:0] d,
                       input logic [3:0] p, input string tag);
      bit bnd, eack;
      logic [11:0] e;
      bnd  = (cur == 2'd3) && (c == 2'd0);
      eack = 1'b0;
      refresh_count = c;
      if (ld) begin digits_in = d; dp_in = p; load = 1'b1; end
      if (bnd) begin
         if (ld) begin m_dig = d; m_dp = p; eack = 1'b1; end
         else if (m_pend) begin m_dig = m_pdig; m_dp = m_pdp; eack = 1'b1; end
         m_pend = 1'b0;
      end else if (ld) begin
         m_pdig = d; m_pdp = p; m_pend = 1'b1;
      end
      cur = c;
      sb.push_back(exp_disp(c));
      @(posedge clk); #1;
      chk({tag, "_ack"}, load_ack, eack);
      if (have_shown) chk({tag, "_hold"}, {an, seg, dp}, shown);
      @(negedge clk);
      load = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         chk({tag, "_blank"}, {an, seg, dp}, 12'hFFF);
         if (k == 0) chk({tag, "_ackpulse"}, load_ack, 1'b0);
         @(negedge clk);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      shown = e; have_shown = 1'b1;
      chk({tag, "_drive"}, {an, seg, dp}, e);
      @(negedge clk);
   endtask

   task automatic reset_wait(input string tag);
      bit found;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         chk({tag, "_rblank"}, {an, seg, dp}, 12'hFFF);
         @(negedge clk);
      end
      found = 1'b0;
      for (int k = 0; k < 3 && !found; k++) begin
         @(posedge clk); #1;
         if (an === 4'b1110) found = 1'b1;
         @(negedge clk);
      end
      chk({tag, "_rfound"}, found, 1'b1);
      shown = exp_disp(2'd0); have_shown = 1'b1;
      chk({tag, "_rdigit"}, {an, seg, dp}, shown);
   endtask

   initial begin
      rst_n = 1'b0; refresh_count = 2'd0; digits_in = '0; dp_in = '0; load = 1'b0;
      cur = 2'd0; m_dig = '0; m_dp = '0; m_pdig = '0; m_pdp = '0; m_pend = 1'b0;
      have_shown = 1'b0; shown = '0;
      repeat (2) @(negedge clk);
      chk("rst_an", an, 4'hF);
      chk("rst_seg", seg, 7'h7F);
      chk("rst_dp", dp, 1'b1);
      chk("rst_ack", load_ack, 1'b0);
      rst_n = 1'b1;
      reset_wait("rst");
      chk("rst_zero_seg", seg, 7'h40);
      idle(10, "f0");

      // All-zero frame: only digit 0 lit.
      step(2'd1, 0, 0, 0, "z1"); chk("z1_seg", seg, 7'h7F); idle(10, "z1");
      step(2'd2, 0, 0, 0, "z2"); idle(10, "z2");
      step(2'd3, 0, 0, 0, "z3"); idle(10, "z3");
      step(2'd0, 0, 0, 0, "z0"); chk("z0_an", an, 4'b1110); idle(10, "z0");

      // Mid-frame load waits for the 3->0 boundary.
      step(2'd1, 0, 0, 0, "a1"); load_pulse(16'h12AF, 4'h0, "a1"); idle(9, "a1");
      step(2'd2, 0, 0, 0, "a2"); idle(10, "a2");
      step(2'd3, 0, 0, 0, "a3"); idle(10, "a3");
      a0 = ack_cnt;
      step(2'd0, 0, 0, 0, "b0"); chk("b0_F", seg, 7'h0E); idle(10, "b0");
      chk("b0_ackcnt", ack_cnt - a0, 1);
      step(2'd1, 0, 0, 0, "b1"); chk("b1_A", seg, 7'h08); idle(10, "b1");
      step(2'd2, 0, 0, 0, "b2"); chk("b2_2", seg, 7'h24); idle(10, "b2");
      step(2'd3, 0, 0, 0, "b3"); chk("b3_1", seg, 7'h79);

      // Two loads in one frame: last wins, one ack.
      load_pulse(16'h1111, 4'h0, "c3"); idle(3, "c3");
      load_pulse(16'h2222, 4'h0, "c3"); idle(4, "c3");
      a0 = ack_cnt;
      step(2'd0, 0, 0, 0, "c0"); chk("c0_2", seg, 7'h24); idle(10, "c0");
      chk("c0_ackcnt", ack_cnt - a0, 1);
      step(2'd1, 0, 0, 0, "c1"); idle(10, "c1");
      step(2'd2, 0, 0, 0, "c2"); idle(10, "c2");
      step(2'd3, 0, 0, 0, "c3b"); chk("c3b_2", seg, 7'h24); idle(10, "c3b");

      // Load coincident with the boundary; dp stops suppression.
      step(2'd0, 1, 16'h0005, 4'b0100, "d0"); chk("d0_5", seg, 7'h12); idle(10, "d0");
      step(2'd1, 0, 0, 0, "d1"); idle(10, "d1");
      step(2'd2, 0, 0, 0, "d2"); chk("d2_seg", seg, 7'h40); chk("d2_dp", dp, 1'b0); idle(10, "d2");
      step(2'd3, 0, 0, 0, "d3"); chk("d3_blank", seg, 7'h7F); chk("d3_dp", dp, 1'b1);

      // Two suppressed leading digits.
      load_pulse(16'h00A0, 4'h0, "e3"); idle(9, "e3");
      step(2'd0, 0, 0, 0, "e0"); idle(10, "e0");
      step(2'd1, 0, 0, 0, "e1"); chk("e1_A", seg, 7'h08); idle(10, "e1");
      step(2'd2, 0, 0, 0, "e2"); chk("e2_blank", seg, 7'h7F); idle(10, "e2");
      step(2'd3, 0, 0, 0, "e3b"); idle(10, "e3b");

      // Pending load, non-sequential 3->1 (no commit), then reset mid-blank.
      load_pulse(16'h9999, 4'hF, "r3");
      step(2'd1, 0, 0, 0, "r1"); idle(10, "r1");
      refresh_count = 2'd2;
      @(posedge clk); @(posedge clk); @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst2_an", an, 4'hF);
      chk("rst2_seg", seg, 7'h7F);
      chk("rst2_dp", dp, 1'b1);
      chk("rst2_ack", load_ack, 1'b0);
      refresh_count = 2'd0; cur = 2'd0;
      m_dig = '0; m_dp = '0; m_pend = 1'b0; have_shown = 1'b0;
      a0 = ack_cnt;
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      reset_wait("rst2");
      step(2'd1, 0, 0, 0, "s1"); idle(10, "s1");
      step(2'd2, 0, 0, 0, "s2"); idle(10, "s2");
      step(2'd3, 0, 0, 0, "s3"); idle(10, "s3");
      step(2'd0, 0, 0, 0, "s0"); idle(10, "s0");
      chk("rst2_noack", ack_cnt - a0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
